// File: rtl/qcw_pkg.sv
// qcw_pkg -- shared definitions for the QCW burst sequencer.
// Holds the FSM state encoding, the default phase_shift limits, the
// cycle_limit / cooldown / phase widths and the phase clamp helper.
package qcw_pkg;

  localparam int PHASE_MIN_DEF = 50;
  localparam int PHASE_MAX_DEF = 254;
  localparam int PHASE_W       = 8;
  localparam int CYCLE_LIMIT_W = 16;
  localparam int COOLDOWN_W    = 24;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LAUNCH   = 3'd1,
    ST_RUN      = 3'd2,
    ST_HALTING  = 3'd3,
    ST_COOLDOWN = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  // Clamp a phase value into [lo, hi].
  function automatic logic [PHASE_W-1:0] clamp_phase(
    input logic [PHASE_W-1:0] v,
    input logic [PHASE_W-1:0] lo,
    input logic [PHASE_W-1:0] hi
  );
    logic [PHASE_W-1:0] r;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/qcw_burst_sequencer_if.sv
// qcw_burst_sequencer_if -- handshake bundle between the burst sequencer
// and the bridge driver.
//   drv_start          sequencer -> driver, one-clock start pulse
//   drv_halt           sequencer -> driver, halt request
//   drv_phase_shift    sequencer -> driver, phase_shift (8 bit)
//   drv_cycle_limit    sequencer -> driver, cycle_limit (16 bit)
//   drv_ready          driver -> sequencer, idle/ready
//   drv_cycle_finished driver -> sequencer, per-cycle pulse
//   drv_fault          driver -> sequencer, fault
// Modports: master = sequencer side, slave = driver side.
interface qcw_burst_sequencer_if;
  import qcw_pkg::*;

  logic                     drv_start;
  logic                     drv_halt;
  logic [PHASE_W-1:0]       drv_phase_shift;
  logic [CYCLE_LIMIT_W-1:0] drv_cycle_limit;
  logic                     drv_ready;
  logic                     drv_cycle_finished;
  logic                     drv_fault;

  modport master (
    output drv_start, drv_halt, drv_phase_shift, drv_cycle_limit,
    input  drv_ready, drv_cycle_finished, drv_fault
  );

  modport slave (
    input  drv_start, drv_halt, drv_phase_shift, drv_cycle_limit,
    output drv_ready, drv_cycle_finished, drv_fault
  );

endinterface

// File: rtl/qcw_phase_ramp.sv
// qcw_phase_ramp -- registered phase_shift ramp generator.
//   clk, rst    clock, asynchronous active-high reset (phase -> PHASE_MIN)
//   load        load load_value (already clamped) into the phase register
//   load_value  starting phase of a burst
//   step_en     advance the ramp by one step
//   step        ramp increment
//   limit       ramp ceiling (already clamped, never above PHASE_MAX)
//   phase       registered phase_shift output
module qcw_phase_ramp
  import qcw_pkg::*;
#(
  parameter int PHASE_MIN = PHASE_MIN_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_value,
  input  logic               step_en,
  input  logic [PHASE_W-1:0] step,
  input  logic [PHASE_W-1:0] limit,
  output logic [PHASE_W-1:0] phase
);

  logic [PHASE_W-1:0] phase_r;
  logic [PHASE_W-1:0] next_phase_s;
  logic [PHASE_W:0]   sum_s;

  // Next phase: load, or saturating step computed one bit wider so it cannot wrap
  always_comb begin
    sum_s        = {1'b0, phase_r} + {1'b0, step};
    next_phase_s = phase_r;
    if (load) begin
      next_phase_s = load_value;
    end else if (step_en) begin
      // A ceiling below the start phase means an inverted range: hold.
      if (limit < phase_r) begin
        next_phase_s = phase_r;
      end else if (sum_s > {1'b0, limit}) begin
        next_phase_s = limit;
      end else begin
        next_phase_s = sum_s[PHASE_W-1:0];
      end
    end else begin
      next_phase_s = phase_r;
    end
  end

  // Phase register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r <= PHASE_W'(PHASE_MIN);
    end else begin
      phase_r <= next_phase_s;
    end
  end

  assign phase = phase_r;

endmodule

// File: rtl/qcw_burst_sequencer.sv
// qcw_burst_sequencer -- launches repeated QCW bursts on a bridge driver,
// ramping phase_shift per driver cycle, with stop/abort, watchdog, fault
// latching and a post-burst cooldown.
//   clk, rst            clock, asynchronous active-high reset
//   en                  launch bursts repeatedly
//   phase_start/end     ramp start / final phase_shift (clamped)
//   phase_step          ramp increment per driver cycle
//   burst_cycles        driver cycle_limit per burst
//   cooldown            dead-time clocks after each burst
//   stop, fault_clr     abort running burst / clear latched fault
//   drv                 driver handshake (master modport)
//   busy, fault_latched state != IDLE / state == FAULT
//   burst_count         completed bursts, wrapping
// All outputs are registered; registered outputs are decoded from the next
// state so they line up with the state they describe.
module qcw_burst_sequencer
  import qcw_pkg::*;
#(
  parameter int PHASE_MIN = PHASE_MIN_DEF,
  parameter int PHASE_MAX = PHASE_MAX_DEF,
  parameter int WD_CLKS   = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [PHASE_W-1:0]       phase_start,
  input  logic [PHASE_W-1:0]       phase_end,
  input  logic [PHASE_W-1:0]       phase_step,
  input  logic [CYCLE_LIMIT_W-1:0] burst_cycles,
  input  logic [COOLDOWN_W-1:0]    cooldown,
  input  logic                     stop,
  input  logic                     fault_clr,
  qcw_burst_sequencer_if.master    drv,
  output logic                     busy,
  output logic                     fault_latched,
  output logic [15:0]              burst_count
);

  localparam int                 WD_W    = $clog2(WD_CLKS + 1);
  localparam logic [WD_W-1:0]    WD_LAST = WD_W'(WD_CLKS - 1);
  localparam logic [PHASE_W-1:0] PMIN8   = PHASE_W'(PHASE_MIN);
  localparam logic [PHASE_W-1:0] PMAX8   = PHASE_W'(PHASE_MAX);

  state_e                   state_r;
  state_e                   next_state_s;
  logic                     ready_q_r;
  logic [WD_W-1:0]          wd_r;
  logic [COOLDOWN_W-1:0]    cd_r;
  logic [PHASE_W-1:0]       cfg_end_r;
  logic [PHASE_W-1:0]       cfg_step_r;
  logic [COOLDOWN_W-1:0]    cfg_cooldown_r;
  logic                     start_r;
  logic                     halt_r;
  logic                     busy_r;
  logic                     fault_r;
  logic [15:0]              count_r;
  logic [CYCLE_LIMIT_W-1:0] cycle_limit_r;
  logic [PHASE_W-1:0]       phase_s;
  logic [PHASE_W-1:0]       start_clamped_s;
  logic                     ready_rise_s;
  logic                     wd_trip_s;
  logic                     launch_s;
  logic                     complete_s;
  logic                     cd_load_s;
  logic [COOLDOWN_W-1:0]    cd_val_s;
  logic                     wd_halt_s;

  assign start_clamped_s = clamp_phase(phase_start, PMIN8, PMAX8);
  assign ready_rise_s    = drv.drv_ready & ~ready_q_r;
  // The watchdog trips on the clock the counter would reach WD_CLKS.
  assign wd_trip_s       = (wd_r == WD_LAST) & ~drv.drv_cycle_finished;

  // Next-state and transition strobes; priority fault > watchdog > stop,
  // except that a ready rise coinciding with stop still counts as completion
  always_comb begin
    next_state_s = state_r;
    launch_s     = 1'b0;
    complete_s   = 1'b0;
    cd_load_s    = 1'b0;
    cd_val_s     = cfg_cooldown_r;
    wd_halt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en && drv.drv_ready && !drv.drv_fault) begin
          next_state_s = ST_LAUNCH;
          launch_s     = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        if (drv.drv_fault) begin
          next_state_s = ST_FAULT;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (drv.drv_fault) begin
          next_state_s = ST_FAULT;
        end else if (wd_trip_s) begin
          next_state_s = ST_FAULT;
          wd_halt_s    = 1'b1;
        end else if (ready_rise_s) begin
          next_state_s = ST_COOLDOWN;
          complete_s   = 1'b1;
          cd_load_s    = 1'b1;
        end else if (stop) begin
          next_state_s = ST_HALTING;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_HALTING: begin
        if (drv.drv_fault) begin
          next_state_s = ST_FAULT;
        end else if (wd_trip_s) begin
          next_state_s = ST_FAULT;
          wd_halt_s    = 1'b1;
        end else if (drv.drv_ready) begin
          next_state_s = ST_COOLDOWN;
          cd_load_s    = 1'b1;
        end else begin
          next_state_s = ST_HALTING;
        end
      end
      ST_COOLDOWN: begin
        // Timer loaded with N gives max(N,1) COOLDOWN clocks.
        if (drv.drv_fault) begin
          next_state_s = ST_FAULT;
        end else if (cd_r <= 24'd1) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_COOLDOWN;
        end
      end
      ST_FAULT: begin
        if (fault_clr && !drv.drv_fault) begin
          next_state_s = ST_COOLDOWN;
          cd_load_s    = 1'b1;
          cd_val_s     = cooldown;
        end else begin
          next_state_s = ST_FAULT;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Registered status/handshake outputs decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_r <= 1'b0;
      halt_r  <= 1'b0;
      busy_r  <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      start_r <= (next_state_s == ST_LAUNCH);
      halt_r  <= (next_state_s == ST_HALTING) | wd_halt_s;
      busy_r  <= (next_state_s != ST_IDLE);
      fault_r <= (next_state_s == ST_FAULT);
    end
  end

  // Burst config latched on entry to LAUNCH and held for the whole burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_end_r      <= 8'd0;
      cfg_step_r     <= 8'd0;
      cfg_cooldown_r <= 24'd0;
      cycle_limit_r  <= 16'd0;
    end else if (launch_s) begin
      cfg_end_r      <= clamp_phase(phase_end, PMIN8, PMAX8);
      cfg_step_r     <= phase_step;
      cfg_cooldown_r <= cooldown;
      cycle_limit_r  <= burst_cycles;
    end
  end

  // Completed-burst counter and driver-ready edge detector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r   <= 16'd0;
      ready_q_r <= 1'b0;
    end else begin
      ready_q_r <= drv.drv_ready;
      if (complete_s) begin
        count_r <= count_r + 16'd1;
      end
    end
  end

  // Watchdog: clocks since the last driver cycle pulse while RUN/HALTING
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_r <= '0;
    end else if ((state_r == ST_RUN || state_r == ST_HALTING) && !drv.drv_cycle_finished) begin
      wd_r <= wd_r + WD_W'(1);
    end else begin
      wd_r <= '0;
    end
  end

  // Cooldown timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cd_r <= 24'd0;
    end else if (cd_load_s) begin
      cd_r <= cd_val_s;
    end else if (state_r == ST_COOLDOWN && cd_r != 24'd0) begin
      cd_r <= cd_r - 24'd1;
    end
  end

  qcw_phase_ramp #(
    .PHASE_MIN (PHASE_MIN)
  ) u_ramp (
    .clk        (clk),
    .rst        (rst),
    .load       (launch_s),
    .load_value (start_clamped_s),
    .step_en    ((state_r == ST_RUN) && drv.drv_cycle_finished),
    .step       (cfg_step_r),
    .limit      (cfg_end_r),
    .phase      (phase_s)
  );

  assign drv.drv_start       = start_r;
  assign drv.drv_halt        = halt_r;
  assign drv.drv_phase_shift = phase_s;
  assign drv.drv_cycle_limit = cycle_limit_r;
  assign busy                = busy_r;
  assign fault_latched       = fault_r;
  assign burst_count         = count_r;

endmodule
